// File: rtl/axi_rd_arbiter.sv
// Three-way AXI read arbiter: one outstanding burst, AR registered, R routed back to the granted requester.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin priority; default is fixed s2 > s1 > s0.
`timescale 1ns/1ps
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_arvalid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [LEN_W-1:0]  s0_arlen,
  input  logic [2:0]        s0_arsize,
  output logic              s0_arready,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic              s1_arvalid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [LEN_W-1:0]  s1_arlen,
  input  logic [2:0]        s1_arsize,
  output logic              s1_arready,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  input  logic              s2_arvalid,
  input  logic [ADDR_W-1:0] s2_araddr,
  input  logic [LEN_W-1:0]  s2_arlen,
  input  logic [2:0]        s2_arsize,
  output logic              s2_arready,
  output logic              s2_rvalid,
  input  logic              s2_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_rlast,
  output logic [1:0]        s_rresp,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              rid_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic              rid_err_q, rid_err_d;
  logic [1:0]        win;
  logic              ar_hs, in_data, sel_rready, beat, any_req;

  assign any_req = s0_arvalid | s1_arvalid | s2_arvalid;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;
  logic [3:0] req;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign req = {1'b0, s2_arvalid, s1_arvalid, s0_arvalid};

  // Search starts just after the previous winner and wraps around.
  always_comb begin
    logic [1:0] p1, p2;
    p1 = inc3(last_q);
    p2 = inc3(p1);
    if (req[p1])      win = p1;
    else if (req[p2]) win = p2;
    else              win = last_q;
  end

  always_comb begin
    last_d = last_q;
    if (ar_hs) last_d = grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 2'd2;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    if (s2_arvalid)      win = 2'd2;
    else if (s1_arvalid) win = 2'd1;
    else                 win = 2'd0;
  end
`endif

  always_comb begin
    case (grant_q)
      2'd0:    sel_rready = s0_rready;
      2'd1:    sel_rready = s1_rready;
      default: sel_rready = s2_rready;
    endcase
  end

  assign m_arvalid = (state_q == ADDR);
  assign ar_hs     = m_arvalid & m_arready;
  assign in_data   = (state_q == DATA);
  assign m_rready  = in_data & sel_rready;
  assign beat      = in_data & m_rvalid & m_rready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    rid_err_d = rid_err_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = win;
          state_d = ADDR;
          case (win)
            2'd0: begin araddr_d = s0_araddr; arlen_d = s0_arlen; arsize_d = s0_arsize; end
            2'd1: begin araddr_d = s1_araddr; arlen_d = s1_arlen; arsize_d = s1_arsize; end
            default: begin araddr_d = s2_araddr; arlen_d = s2_arlen; arsize_d = s2_arsize; end
          endcase
        end
      end
      ADDR: if (ar_hs) state_d = DATA;
      DATA: if (beat && m_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A mismatched ID is flagged but the beat is still delivered.
    if (beat && (m_rid != ID_W'(grant_q))) rid_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'd0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      rid_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      rid_err_q <= rid_err_d;
    end
  end

  assign m_arid     = ID_W'(grant_q);
  assign m_araddr   = araddr_q;
  assign m_arlen    = arlen_q;
  assign m_arsize   = arsize_q;
  assign m_arburst  = 2'b01;
  assign rid_err    = rid_err_q;

  assign s0_arready = ar_hs & (grant_q == 2'd0);
  assign s1_arready = ar_hs & (grant_q == 2'd1);
  assign s2_arready = ar_hs & (grant_q == 2'd2);
  assign s0_rvalid  = in_data & m_rvalid & (grant_q == 2'd0);
  assign s1_rvalid  = in_data & m_rvalid & (grant_q == 2'd1);
  assign s2_rvalid  = in_data & m_rvalid & (grant_q == 2'd2);

  assign s_rdata    = m_rdata;
  assign s_rlast    = m_rlast;
  assign s_rresp    = m_rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: transaction-level model checked every cycle, directed scenarios, then random traffic.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  arv, arrdy, rv, rr;
  logic [31:0] ara [3];
  logic [3:0]  arl [3];
  logic [2:0]  ars [3];
  logic [31:0] s_rdata, m_araddr, m_rdata;
  logic        s_rlast, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, rid_err;
  logic [1:0]  s_rresp, m_arburst, m_rresp;
  logic [3:0]  m_arid, m_arlen, m_rid;
  logic [2:0]  m_arsize;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(4), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .s0_arvalid(arv[0]), .s0_araddr(ara[0]), .s0_arlen(arl[0]), .s0_arsize(ars[0]),
    .s0_arready(arrdy[0]), .s0_rvalid(rv[0]), .s0_rready(rr[0]),
    .s1_arvalid(arv[1]), .s1_araddr(ara[1]), .s1_arlen(arl[1]), .s1_arsize(ars[1]),
    .s1_arready(arrdy[1]), .s1_rvalid(rv[1]), .s1_rready(rr[1]),
    .s2_arvalid(arv[2]), .s2_araddr(ara[2]), .s2_arlen(arl[2]), .s2_arsize(ars[2]),
    .s2_arready(arrdy[2]), .s2_rvalid(rv[2]), .s2_rready(rr[2]),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rresp(s_rresp),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .rid_err(rid_err)
  );

  int checks = 0, failures = 0, cyc = 0;

  // stimulus agents
  bit          have_req [3];
  logic [31:0] req_addr [3];
  logic [3:0]  req_len  [3];
  logic [2:0]  req_size [3];
  bit          rnd, gen_en, s_busy;
  int          arr_hold, s_cnt, stall_req, stall_beat, stall_done, rid_bad_beat;
  logic [3:0]  s_id, s_len;

  // observations of the previous cycle, taken on the falling edge
  logic [2:0]  obs_arhs;
  bit          obs_mar, obs_beat, obs_rlast, obs_marv;
  logic [3:0]  obs_arid, obs_arlen;

  // statistics used by the directed checks
  int          recv [3], arrdy_cnt [3], arv_rise [3];
  int          stall_cnt, rstall_cnt, addr_chg, marv_rise;
  logic [2:0]  prev_arv;
  bit          prev_marv, prev_mar_hs;
  logic [31:0] prev_addr;
  int          log_id[$], log_len[$], log_burst[$], log_cyc[$];
  logic [31:0] log_addr[$];

  // transaction-level model: the burst in flight (if any) and whether its AR is done
  bit          mv, mdone, merr;
  logic [1:0]  mid, mlast;
  logic [31:0] maddr;
  logic [3:0]  mlen;
  logic [2:0]  msize;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      int p;
      p = (int'(last) + k) % 3;
      if (r[p]) return 2'(p);
    end
    return last;
`else
    if (last > 2'd2) return 2'd0;
    for (int p = 2; p >= 0; p--) if (r[p]) return 2'(p);
    return 2'd0;
`endif
  endfunction

  task automatic check_cycle();
    logic [2:0] e_arrdy, e_rv;
    bit e_arv;
    cyc++;
    if (rst) begin
      chk("rst_m_arvalid", m_arvalid, 0);
      chk("rst_m_rready", m_rready, 0);
      chk("rst_arready", arrdy, 0);
      chk("rst_rvalid", rv, 0);
      chk("rst_rid_err", rid_err, 0);
      chk("rst_m_arid", m_arid, 0);
      mv = 0; mdone = 0; merr = 0; mlast = 2'd2;
      obs_arhs = 0; obs_mar = 0; obs_beat = 0; obs_rlast = 0; obs_marv = 0;
      prev_arv = 0; prev_marv = 0; prev_mar_hs = 0;
      return;
    end
    e_arv = mv && !mdone;
    chk("m_arvalid", m_arvalid, e_arv);
    if (e_arv) begin
      chk("m_arid", m_arid, 4'(mid));
      chk("m_araddr", m_araddr, maddr);
      chk("m_arlen", m_arlen, mlen);
      chk("m_arsize", m_arsize, msize);
      chk("m_arburst", m_arburst, 2'b01);
    end
    e_arrdy = 0; e_rv = 0;
    for (int n = 0; n < 3; n++) begin
      e_arrdy[n] = e_arv && (mid == 2'(n)) && m_arready;
      e_rv[n]    = mv && mdone && (mid == 2'(n)) && m_rvalid;
    end
    chk("sN_arready", arrdy, e_arrdy);
    chk("sN_rvalid", rv, e_rv);
    chk("m_rready", m_rready, mv && mdone && rr[mid]);
    if (mv && mdone && m_rvalid) begin
      chk("s_rdata", s_rdata, m_rdata);
      chk("s_rlast", s_rlast, m_rlast);
      chk("s_rresp", s_rresp, m_rresp);
    end
    chk("rid_err", rid_err, merr);

    obs_arhs = arrdy; obs_mar = m_arvalid && m_arready; obs_arid = m_arid; obs_arlen = m_arlen;
    obs_beat = m_rvalid && m_rready; obs_rlast = m_rlast; obs_marv = m_arvalid;
    if (obs_mar) begin
      log_id.push_back(int'(m_arid)); log_addr.push_back(m_araddr);
      log_len.push_back(int'(m_arlen)); log_burst.push_back(int'(m_arburst)); log_cyc.push_back(cyc);
    end
    for (int n = 0; n < 3; n++) begin
      if (rv[n] && rr[n]) recv[n]++;
      if (arrdy[n]) arrdy_cnt[n]++;
      if (arv[n] && !prev_arv[n]) arv_rise[n] = cyc;
    end
    if (m_arvalid && !prev_marv) marv_rise = cyc;
    if (m_arvalid && !m_arready) stall_cnt++;
    if (m_rvalid && !m_rready) rstall_cnt++;
    if (m_arvalid && prev_marv && !prev_mar_hs && m_araddr != prev_addr) addr_chg++;
    prev_arv = arv; prev_marv = m_arvalid; prev_mar_hs = obs_mar; prev_addr = m_araddr;

    // advance the model by one clock using only the stimulus it saw
    if (!mv) begin
      if (|arv) begin
        mid = pick(arv, mlast);
        mv = 1; mdone = 0;
        maddr = ara[mid]; mlen = arl[mid]; msize = ars[mid];
      end
    end else if (!mdone) begin
      if (m_arready) begin mdone = 1; mlast = mid; end
    end else if (m_rvalid && rr[mid]) begin
      if (m_rid != 4'(mid)) merr = 1;
      if (m_rlast) mv = 0;
    end
  endtask

  task automatic drive();
    for (int n = 0; n < 3; n++) begin
      if (obs_arhs[n]) have_req[n] = 0;
      if (!have_req[n] && gen_en && $urandom_range(0, 7) == 0) begin
        have_req[n] = 1;
        req_addr[n] = $urandom;
        req_len[n]  = 4'($urandom_range(0, 7));
        req_size[n] = 3'($urandom_range(0, 2));
      end
      arv[n] = have_req[n]; ara[n] = req_addr[n]; arl[n] = req_len[n]; ars[n] = req_size[n];
    end
    if (obs_marv && arr_hold > 0) arr_hold--;
    m_arready = (arr_hold > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    if (obs_beat) begin
      s_cnt++;
      if (obs_rlast) s_busy = 0;
      m_rvalid = 0;
    end
    if (obs_mar) begin s_busy = 1; s_id = obs_arid; s_len = obs_arlen; s_cnt = 0; end
    if (!s_busy) begin
      m_rvalid = 0; m_rlast = 0;
    end else if (!m_rvalid && (!rnd || $urandom_range(0, 3) != 0)) begin
      m_rvalid = 1;
      m_rdata  = $urandom;
      m_rlast  = (s_cnt == int'(s_len));
      m_rresp  = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
      m_rid    = (s_cnt == rid_bad_beat) ? 4'd2 : s_id;
    end
    for (int n = 0; n < 3; n++) begin
      if (stall_req == n && s_busy && s_cnt == stall_beat && stall_done < 2) begin
        rr[n] = 0; stall_done++;
      end else rr[n] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (((|{have_req[0], have_req[1], have_req[2]}) || s_busy || m_arvalid) && k < budget) begin
      step(); k++;
    end
    step();
    chk({"timeout_", nm}, k >= budget, 0);
  endtask

  task automatic post(input int n, input logic [31:0] a, input logic [3:0] l);
    have_req[n] = 1; req_addr[n] = a; req_len[n] = l; req_size[n] = 3'd2;
  endtask

  task automatic pulse_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  int base, r0, r1, r2, sc, pc, ac, rs;
  int exp_ord [3];

  initial begin
    rst = 1;
    arv = 0; rr = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rid = 0; m_rdata = 0; m_rresp = 0;
    for (int n = 0; n < 3; n++) begin
      have_req[n] = 0; req_addr[n] = 0; req_len[n] = 0; req_size[n] = 0;
      ara[n] = 0; arl[n] = 0; ars[n] = 0; recv[n] = 0; arrdy_cnt[n] = 0; arv_rise[n] = 0;
    end
    rnd = 0; gen_en = 0; s_busy = 0; arr_hold = 0; s_cnt = 0; s_id = 0; s_len = 0;
    stall_req = -1; stall_beat = -1; stall_done = 0; rid_bad_beat = -1;
    stall_cnt = 0; rstall_cnt = 0; addr_chg = 0; marv_rise = 0;
    repeat (3) step();
    rst = 0;

    // single s1 burst of 8 beats
    base = log_id.size(); r0 = recv[0]; r1 = recv[1]; r2 = recv[2];
    post(1, 32'h1FC0_0100, 4'd7);
    wait_idle(100, "t1");
    chk("t1_nar", log_id.size() - base, 1);
    chk("t1_arid", log_id[base], 1);
    chk("t1_araddr", log_addr[base], 32'h1FC0_0100);
    chk("t1_arlen", log_len[base], 7);
    chk("t1_arburst", log_burst[base], 1);
    chk("t1_s1_beats", recv[1] - r1, 8);
    chk("t1_other_beats", (recv[0] - r0) + (recv[2] - r2), 0);
    chk("t1_latency", marv_rise - arv_rise[1], 1);

    // three simultaneous requesters, two rounds
`ifdef ARB_ROUND_ROBIN_EN
    exp_ord = '{0, 1, 2};
`else
    exp_ord = '{2, 1, 0};
`endif
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      base = log_id.size();
      post(0, 32'h0000_1000, 4'd0); post(1, 32'h0000_2000, 4'd0); post(2, 32'h0000_3000, 4'd0);
      wait_idle(100, "t2");
      chk("t2_nar", log_id.size() - base, 3);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t2_order_r%0d_%0d", r, k), log_id[base + k], exp_ord[k]);
        if (k > 0) chk($sformatf("t2_gap_r%0d_%0d", r, k), log_cyc[base + k] - log_cyc[base + k - 1], 3);
      end
    end

    // AR stalled 5 cycles
    sc = stall_cnt; pc = arrdy_cnt[2]; ac = addr_chg; base = log_id.size();
    arr_hold = 5;
    post(2, 32'h8000_0040, 4'd1);
    wait_idle(100, "t4");
    chk("t4_stall_cycles", stall_cnt - sc, 5);
    chk("t4_s2_arready_pulses", arrdy_cnt[2] - pc, 1);
    chk("t4_addr_changes", addr_chg - ac, 0);
    chk("t4_araddr", log_addr[base], 32'h8000_0040);

    // rready stall on beat 3, wrong ID on beat 4
    r1 = recv[1]; rs = rstall_cnt;
    stall_req = 1; stall_beat = 2; stall_done = 0; rid_bad_beat = 3;
    post(1, 32'h0000_5000, 4'd3);
    wait_idle(100, "t5");
    chk("t5_s1_beats", recv[1] - r1, 4);
    chk("t5_rready_stall", rstall_cnt - rs, 2);
    chk("t5_rid_err", rid_err, 1);
    stall_req = -1; rid_bad_beat = -1;
    repeat (5) step();
    chk("t5_rid_err_sticky", rid_err, 1);

    // asynchronous reset in the middle of a burst
    r0 = recv[0];
    post(0, 32'h0000_4000, 4'd15);
    for (int k = 0; k < 100 && recv[0] - r0 < 3; k++) step();
    chk("t6_in_data", recv[0] - r0 >= 3, 1);
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("t6_m_rready", m_rready, 0);
    chk("t6_s0_rvalid", rv[0], 0);
    chk("t6_m_arvalid", m_arvalid, 0);
    chk("t6_arready", arrdy, 0);
    chk("t6_rid_err", rid_err, 0);
    for (int n = 0; n < 3; n++) have_req[n] = 0;
    s_busy = 0; m_rvalid = 0; m_rlast = 0; arv = 0;
    step(); step();
    rst = 0;
    base = log_id.size(); r0 = recv[0];
    post(0, 32'h0000_2000, 4'd3);
    wait_idle(100, "t6b");
    chk("t6_arid", log_id[base], 0);
    chk("t6_araddr", log_addr[base], 32'h0000_2000);
    chk("t6_s0_beats", recv[0] - r0, 4);

    // random traffic with random stalls on every handshake
    rnd = 1; gen_en = 1;
    repeat (4000) step();
    gen_en = 0;
    wait_idle(3000, "rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
